// File: rtl/inst_inject_pkg.sv
// -----------------------------------------------------------------------------
// inst_inject_pkg
// Shared definitions for the instruction word injection selector.
//   DEFAULT_WORD_W : default instruction word width
//   NOP_WORD       : all-zero NOP encoding, used as the reset value of the
//                    output instruction word
//   inj_state_e    : FSM states (ST_FETCH = FIFO empty, ST_INJECT = FIFO busy)
// -----------------------------------------------------------------------------
package inst_inject_pkg;

    localparam int DEFAULT_WORD_W = 32;

    localparam logic [DEFAULT_WORD_W-1:0] NOP_WORD = '0;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_INJECT = 1'b1
    } inj_state_e;

endpackage : inst_inject_pkg

// File: rtl/inst_inject_fifo.sv
// -----------------------------------------------------------------------------
// inst_inject_fifo
// Synchronous FIFO buffering granted injection words ahead of the fetch stream.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wr_data   write request and data (ignored while full)
//   pop, rd_data    read request (ignored while empty), head-of-queue data
//   flush           discards all entries; wins over push and pop
//   count           current occupancy
//   full, empty     derived from count
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module inst_inject_fifo
    import inst_inject_pkg::*;
#(
    parameter  int WORD_W     = DEFAULT_WORD_W,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              pop,
    input  logic              flush,
    output logic [WORD_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_en;
    logic              pop_en;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full & ~flush;
    assign pop_en  = pop & ~empty & ~flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count/pointers already mark every
    // entry invalid, and a reset here would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wr_data;
    end

endmodule : inst_inject_fifo

// File: rtl/inst_word_inject_sel.sv
// -----------------------------------------------------------------------------
// inst_word_inject_sel
// Selects the instruction word handed to decode: either the program-memory
// word or a word from one of NUM_SRC injection sources. Injections are
// arbitrated (fixed priority, index 0 highest), buffered in a FIFO and
// delivered ahead of the fetch stream while the PC is held.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   prog_mem_out/valid  word fetched at the current PC and its qualifier
//   inj_valid/inj_word  per-source requests; source i at [i*WORD_W +: WORD_W]
//   inj_ready           one-hot grant (transfer on inj_valid & inj_ready)
//   decode_ready        decode accepts instruction_word this cycle
//   flush               discards buffered and output words
//   instruction_word    registered word to decode
//   instruction_valid   instruction_word is valid
//   inject_active       instruction_word came from an injection source
//   pc_hold             combinational: PC must not advance this cycle
//   fifo_count          injection FIFO occupancy
//
// Build option INST_INJECT_BYPASS_EN: a grant arriving while the FIFO is empty
// and the output register is loading is written straight into the output
// register (1-cycle injection latency) instead of being pushed.
// -----------------------------------------------------------------------------
module inst_word_inject_sel
    import inst_inject_pkg::*;
#(
    parameter  int WORD_W     = DEFAULT_WORD_W,
    parameter  int NUM_SRC    = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_W-1:0]         prog_mem_out,
    input  logic                      prog_mem_valid,
    input  logic [NUM_SRC-1:0]        inj_valid,
    input  logic [NUM_SRC*WORD_W-1:0] inj_word,
    output logic [NUM_SRC-1:0]        inj_ready,
    input  logic                      decode_ready,
    input  logic                      flush,
    output logic [WORD_W-1:0]         instruction_word,
    output logic                      instruction_valid,
    output logic                      inject_active,
    output logic                      pc_hold,
    output logic [CNT_W-1:0]          fifo_count
);

    logic [NUM_SRC-1:0] grant;
    logic               grant_any;
    logic [WORD_W-1:0]  grant_word;
    logic               load;
    logic               bypass;
    logic               push;
    logic               pop;
    logic [WORD_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    inj_state_e         state;
    inj_state_e         state_next;

    // Fixed-priority arbiter. Scanning from the highest index down lets the
    // lowest requesting index overwrite any earlier pick, so it wins.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch can be inferred.
    always_comb begin
        grant      = '0;
        grant_word = '0;
        if (!rst && !flush && !fifo_full) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (inj_valid[i]) begin
                    grant      = '0;
                    grant[i]   = 1'b1;
                    grant_word = inj_word[i*WORD_W +: WORD_W];
                end
            end
        end
    end

    assign inj_ready = grant;
    assign grant_any = |grant;
    assign load      = ~instruction_valid | decode_ready;

`ifdef INST_INJECT_BYPASS_EN
    // Empty FIFO and a loading output register: skip the FIFO entirely.
    assign bypass = grant_any & fifo_empty & load;
`else
    assign bypass = 1'b0;
`endif

    assign push = grant_any & ~bypass;
    assign pop  = load & ~fifo_empty & ~flush;

    // The bypassed word displaces the program word this cycle, so the PC
    // must not advance either.
    assign pc_hold = ~fifo_empty | (instruction_valid & ~decode_ready) | bypass;

    inst_inject_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (grant_word),
        .pop     (pop),
        .flush   (flush),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // FSM tracks whether injected words are outstanding in the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_FETCH;
        end else begin
            unique case (state)
                ST_FETCH:  if (push) state_next = ST_INJECT;
                ST_INJECT: if (pop && !push && fifo_count == CNT_W'(1))
                               state_next = ST_FETCH;
                default:   state_next = ST_FETCH;
            endcase
        end
    end

    // Output register: FIFO head first, then a bypassed grant, then program
    // memory; with nothing to offer the output goes invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_word  <= WORD_W'(NOP_WORD);
            instruction_valid <= 1'b0;
            inject_active     <= 1'b0;
        end else if (flush) begin
            instruction_valid <= 1'b0;
            inject_active     <= 1'b0;
        end else if (load) begin
            if (!fifo_empty) begin
                instruction_word  <= fifo_head;
                instruction_valid <= 1'b1;
                inject_active     <= 1'b1;
            end else if (bypass) begin
                instruction_word  <= grant_word;
                instruction_valid <= 1'b1;
                inject_active     <= 1'b1;
            end else if (prog_mem_valid) begin
                instruction_word  <= prog_mem_out;
                instruction_valid <= 1'b1;
                inject_active     <= 1'b0;
            end else begin
                instruction_valid <= 1'b0;
                inject_active     <= 1'b0;
            end
        end
    end

endmodule : inst_word_inject_sel

// File: tb/tb_inst_word_inject_sel.sv
// -----------------------------------------------------------------------------
// tb_inst_word_inject_sel
// Self-checking bench for inst_word_inject_sel. A queue-based reference model
// tracks the injection buffer and the word presented to decode; directed
// scenarios cover reset, fetch, priority, full FIFO, flush, mid-run reset and
// injection latency, followed by a randomized run. Honors INST_INJECT_BYPASS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_word_inject_sel;
    import inst_inject_pkg::*;

    localparam int WORD_W     = 32;
    localparam int NUM_SRC    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [WORD_W-1:0]         prog_mem_out;
    logic                      prog_mem_valid;
    logic [NUM_SRC-1:0]        inj_valid;
    logic [NUM_SRC*WORD_W-1:0] inj_word;
    logic [NUM_SRC-1:0]        inj_ready;
    logic                      decode_ready;
    logic                      flush;
    logic [WORD_W-1:0]         instruction_word;
    logic                      instruction_valid;
    logic                      inject_active;
    logic                      pc_hold;
    logic [CNT_W-1:0]          fifo_count;

    inst_word_inject_sel #(
        .WORD_W     (WORD_W),
        .NUM_SRC    (NUM_SRC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .prog_mem_out      (prog_mem_out),
        .prog_mem_valid    (prog_mem_valid),
        .inj_valid         (inj_valid),
        .inj_word          (inj_word),
        .inj_ready         (inj_ready),
        .decode_ready      (decode_ready),
        .flush             (flush),
        .instruction_word  (instruction_word),
        .instruction_valid (instruction_valid),
        .inject_active     (inject_active),
        .pc_hold           (pc_hold),
        .fifo_count        (fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [WORD_W-1:0]  mq[$];
    logic               m_valid;
    logic               m_inj;
    logic [WORD_W-1:0]  m_word;
    int                 pc;
    logic [NUM_SRC-1:0] e_ready;
    logic [WORD_W-1:0]  e_gword;
    bit                 e_load;
    bit                 e_bypass;
    bit                 e_hold;

    function automatic logic [WORD_W-1:0] prog_word(int p);
        return 32'h1111_0000 + 32'(p);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_inj   = 1'b0;
        m_word  = '0;
    endfunction

    // Expected combinational outputs for the inputs currently driven.
    function automatic void model_comb();
        bit found;
        found   = 1'b0;
        e_ready = '0;
        e_gword = '0;
        if (!flush && mq.size() < FIFO_DEPTH) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && inj_valid[i]) begin
                    found      = 1'b1;
                    e_ready[i] = 1'b1;
                    e_gword    = inj_word[i*WORD_W +: WORD_W];
                end
            end
        end
        e_load = !m_valid || decode_ready;
`ifdef INST_INJECT_BYPASS_EN
        e_bypass = found && mq.size() == 0 && e_load;
`else
        e_bypass = 1'b0;
`endif
        e_hold = (mq.size() != 0) || (m_valid && !decode_ready) || e_bypass;
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge,
    // then move program memory on if its word was consumed.
    task automatic tick();
        bit prog_taken;
        model_comb();
        @(posedge clk);
        prog_taken = 1'b0;
        if (flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_inj   = 1'b0;
        end else begin
            if (e_load) begin
                if (mq.size() != 0) begin
                    m_word = mq.pop_front(); m_valid = 1'b1; m_inj = 1'b1;
                end else if (e_bypass) begin
                    m_word = e_gword; m_valid = 1'b1; m_inj = 1'b1;
                end else if (prog_mem_valid) begin
                    m_word = prog_mem_out; m_valid = 1'b1; m_inj = 1'b0;
                    prog_taken = 1'b1;
                end else begin
                    m_valid = 1'b0; m_inj = 1'b0;
                end
            end
            if (e_ready != '0 && !e_bypass) mq.push_back(e_gword);
        end
        if (prog_taken) pc++;
        #1;
        prog_mem_out = prog_word(pc);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; decode_ready = 1'b1; prog_mem_valid = 1'b1;
        inj_valid = 2'b11; inj_word = {32'h5555_5555, 32'h6666_6666};
        pc = 1; prog_mem_out = prog_word(pc);
        #1;
        n_vec++; if (instruction_word !== 32'h0) begin n_err++; $display("FAIL reset_word: got %h expected 0", instruction_word); end
        n_vec++; if (instruction_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", instruction_valid); end
        n_vec++; if (inject_active !== 1'b0) begin n_err++; $display("FAIL reset_inj: got %b expected 0", inject_active); end
        n_vec++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_vec++; if (inj_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b expected 00", inj_ready); end
        n_vec++; if (pc_hold !== 1'b0) begin n_err++; $display("FAIL reset_hold: got %b expected 0", pc_hold); end
        @(posedge clk); #1;
        inj_valid = '0; prog_mem_valid = 1'b0; decode_ready = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_prog_fetch();
        prog_mem_valid = 1'b1; decode_ready = 1'b1; inj_valid = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++; if (pc_hold !== 1'b0) begin n_err++; $display("FAIL fetch_hold: got %b expected 0", pc_hold); end
            tick();
            n_vec++; if (instruction_word !== 32'h1111_0001 + 32'(k) || instruction_valid !== 1'b1 || inject_active !== 1'b0)
                begin n_err++; $display("FAIL fetch_word: got %h/%b/%b expected %h/1/0", instruction_word, instruction_valid, inject_active, 32'h1111_0001 + 32'(k)); end
        end
    endtask

    task automatic test_priority();
        logic [WORD_W-1:0] seq[$];
        int ia;
        inj_valid = 2'b11; inj_word = {32'hBBBB_0000, 32'hAAAA_0000};
        #1;
        n_vec++; if (inj_ready !== 2'b01) begin n_err++; $display("FAIL prio_grant0: got %b expected 01", inj_ready); end
        tick();
        if (m_valid) seq.push_back(instruction_word);
        inj_valid = 2'b10;
        #1;
        n_vec++; if (inj_ready !== 2'b10) begin n_err++; $display("FAIL prio_grant1: got %b expected 10", inj_ready); end
        tick();
        if (m_valid) seq.push_back(instruction_word);
        inj_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1; model_comb();
            n_vec++; if (pc_hold !== e_hold) begin n_err++; $display("FAIL prio_hold: got %b expected %b", pc_hold, e_hold); end
            tick();
            n_vec++; if (instruction_word !== m_word || instruction_valid !== m_valid)
                begin n_err++; $display("FAIL prio_word: got %h/%b expected %h/%b", instruction_word, instruction_valid, m_word, m_valid); end
            if (m_valid) seq.push_back(m_word);
        end
        ia = -1;
        for (int i = 0; i < seq.size(); i++) if (ia < 0 && seq[i] == 32'hAAAA_0000) ia = i;
        n_vec++;
        if (ia < 0 || ia + 2 >= seq.size()) begin
            n_err++; $display("FAIL prio_order: src0 word %0d not followed by two words", ia);
        end else if (seq[ia+1] !== 32'hBBBB_0000 || seq[ia+2][31:16] !== 16'h1111) begin
            n_err++; $display("FAIL prio_order: got %h,%h after src0 expected BBBB0000,1111xxxx", seq[ia+1], seq[ia+2]);
        end
    endtask

    task automatic test_fifo_full();
        logic [WORD_W-1:0] pushed[$];
        logic [WORD_W-1:0] held;
        logic [WORD_W-1:0] w;
        held = instruction_word;
        decode_ready = 1'b0; prog_mem_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            w = $urandom; inj_valid = 2'b01; inj_word = {32'h0, w};
            #1;
            n_vec++; if (inj_ready !== ((c < 4) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL full_ready%0d: got %b", c, inj_ready); end
            if (c < 4) pushed.push_back(w);
            tick();
            n_vec++; if (instruction_word !== held || instruction_valid !== 1'b1) begin n_err++; $display("FAIL full_stall: got %h expected %h", instruction_word, held); end
        end
        n_vec++; if (fifo_count !== CNT_W'(4)) begin n_err++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
        decode_ready = 1'b1; inj_word = {32'h0, 32'hDEAD_0000};
        #1;
        n_vec++; if (inj_ready !== 2'b00) begin n_err++; $display("FAIL full_pop_push: got %b expected 00", inj_ready); end
        tick();
        inj_valid = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin #1; tick(); end
            n_vec++; if (instruction_word !== pushed[c] || inject_active !== 1'b1)
                begin n_err++; $display("FAIL full_drain%0d: got %h/%b expected %h/1", c, instruction_word, inject_active, pushed[c]); end
        end
    endtask

    task automatic test_flush();
        decode_ready = 1'b0; prog_mem_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            inj_valid = 2'b01; inj_word = {32'h0, 32'(c) + 32'hF000_0000};
            #1; tick();
        end
        n_vec++; if (fifo_count !== CNT_W'(3)) begin n_err++; $display("FAIL flush_pre: got %0d expected 3", fifo_count); end
        flush = 1'b1; inj_valid = 2'b11;
        #1;
        n_vec++; if (inj_ready !== 2'b00) begin n_err++; $display("FAIL flush_grant: got %b expected 00", inj_ready); end
        tick();
        flush = 1'b0; inj_valid = '0; prog_mem_valid = 1'b0;
        #1;
        n_vec++; if (fifo_count !== '0 || instruction_valid !== 1'b0 || inject_active !== 1'b0)
            begin n_err++; $display("FAIL flush_state: got cnt %0d valid %b inj %b expected 0/0/0", fifo_count, instruction_valid, inject_active); end
        n_vec++; if (dut.state !== ST_FETCH) begin n_err++; $display("FAIL flush_fsm: got %0d expected FETCH", dut.state); end
        n_vec++; if (pc_hold !== 1'b0) begin n_err++; $display("FAIL flush_hold: got %b expected 0", pc_hold); end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W-1:0] exp_w;
        decode_ready = 1'b0; prog_mem_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            inj_valid = 2'b01; inj_word = {32'h0, 32'hE000_0000 + 32'(c)};
            #1; tick();
        end
        n_vec++; if (fifo_count !== CNT_W'(2)) begin n_err++; $display("FAIL rmid_pre: got %0d expected 2", fifo_count); end
        #2; rst = 1'b1;
        #1;
        n_vec++; if (instruction_word !== '0 || instruction_valid !== 1'b0 || inject_active !== 1'b0 || fifo_count !== '0 || inj_ready !== '0 || pc_hold !== 1'b0)
            begin n_err++; $display("FAIL rmid_clear: got %h/%b/%b/%0d/%b/%b expected all zero", instruction_word, instruction_valid, inject_active, fifo_count, inj_ready, pc_hold); end
        @(posedge clk); #1;
        rst = 1'b0; model_reset();
        inj_valid = '0; decode_ready = 1'b1; prog_mem_valid = 1'b1;
        exp_w = prog_word(pc);
        #1; tick();
        n_vec++; if (instruction_word !== exp_w || instruction_valid !== 1'b1 || inject_active !== 1'b0)
            begin n_err++; $display("FAIL rmid_resume: got %h/%b/%b expected %h/1/0", instruction_word, instruction_valid, inject_active, exp_w); end
    endtask

    task automatic test_inject_latency();
        prog_mem_valid = 1'b0; decode_ready = 1'b1; inj_valid = '0;
        #1; tick();
        inj_valid = 2'b10; inj_word = {32'hCCCC_0000, 32'h0};
        #1; tick();
        inj_valid = '0;
`ifdef INST_INJECT_BYPASS_EN
        n_vec++; if (instruction_word !== 32'hCCCC_0000 || instruction_valid !== 1'b1 || inject_active !== 1'b1 || fifo_count !== '0)
            begin n_err++; $display("FAIL lat_bypass: got %h/%b/%b/%0d expected CCCC0000/1/1/0", instruction_word, instruction_valid, inject_active, fifo_count); end
`else
        n_vec++; if (instruction_valid !== 1'b0 || fifo_count !== CNT_W'(1))
            begin n_err++; $display("FAIL lat_edge1: got valid %b cnt %0d expected 0/1", instruction_valid, fifo_count); end
        #1; tick();
        n_vec++; if (instruction_word !== 32'hCCCC_0000 || instruction_valid !== 1'b1 || inject_active !== 1'b1 || fifo_count !== '0)
            begin n_err++; $display("FAIL lat_edge2: got %h/%b/%b/%0d expected CCCC0000/1/1/0", instruction_word, instruction_valid, inject_active, fifo_count); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            flush          = ($urandom_range(15) == 0);
            decode_ready   = ($urandom_range(2) != 0);
            prog_mem_valid = ($urandom_range(3) != 0);
            inj_valid      = NUM_SRC'($urandom);
            inj_word       = {$urandom, $urandom};
            #1; model_comb();
            n_vec++; if (inj_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, inj_ready, e_ready); end
            n_vec++; if (pc_hold !== e_hold) begin n_err++; $display("FAIL rnd_hold@%0d: got %b expected %b", c, pc_hold, e_hold); end
            tick();
            n_vec++; if (instruction_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, instruction_valid, m_valid); end
            if (m_valid) begin
                n_vec++; if (instruction_word !== m_word || inject_active !== m_inj)
                    begin n_err++; $display("FAIL rnd_word@%0d: got %h/%b expected %h/%b", c, instruction_word, inject_active, m_word, m_inj); end
            end
            n_vec++; if (fifo_count !== CNT_W'(mq.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, fifo_count, mq.size()); end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prog_fetch();
        test_priority();
        test_fifo_full();
        test_flush();
        test_reset_mid();
        test_inject_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_inst_word_inject_sel

// File: doc/inst_word_inject_sel.md
# inst_word_inject_sel

Registered, parametrised successor to the fetch-stage instruction word selector. It drives the decode stage's instruction word from program memory or from one of NUM_SRC injection sources (hazard call, interrupt call, debug). Injected words are arbitrated, buffered in a small FIFO and inserted ahead of the fetch stream. While injected words are pending, the PC is held so no program word is lost.

## Interface
Parameters:
- WORD_W, 32, instruction word width
- NUM_SRC, 2, number of injection sources; index 0 has highest priority
- FIFO_DEPTH, 4, injection FIFO depth; power of two, ≥2

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset; asynchronous, active-high
- prog_mem_out  in  WORD_W  word fetched at current PC
- prog_mem_valid  in  1  prog_mem_out is valid this cycle
- inj_valid  in  NUM_SRC  per-source injection request
- inj_word  in  NUM_SRC*WORD_W  per-source words; source i at bits [i*WORD_W +: WORD_W]
- inj_ready  out  NUM_SRC  one-hot grant; a word transfers on inj_valid[i] & inj_ready[i]
- decode_ready  in  1  decode stage accepts instruction_word this cycle
- flush  in  1  branch/redirect; discards buffered and output words
- instruction_word  out  WORD_W  registered word to decode
- instruction_valid  out  1  instruction_word is valid
- inject_active  out  1  instruction_word came from an injection source
- pc_hold  out  1  combinational; PC must not advance this cycle
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

## Operation
- **Arbiter.** Fixed priority, lowest index wins.
  - inj_ready[i] = 1 only for the winning requester, and only when FIFO not full, flush=0 and rst=0.
  - At most one push per cycle.
- **Full FIFO.** Push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- **Output register.** It loads when `load = ~instruction_valid | decode_ready`.
  - Source priority on load: FIFO head, then prog_mem_out if prog_mem_valid, else instruction_valid←0.
  - inject_active is set to 1 when the word comes from the FIFO and to 0 when it comes from program memory.
- **pc_hold.** pc_hold = (FIFO non-empty) | (instruction_valid & ~decode_ready).
  - Program memory keeps presenting the same word until a program-memory load occurs.
- **FSM, two states.**
  - FETCH: FIFO empty. Goes to INJECT on a push.
  - INJECT: FIFO non-empty. Goes to FETCH when the last entry pops with no simultaneous push.
  - Flush from either state goes to FETCH.
- **flush.**
  - Clears the FIFO (fifo_count←0), clears instruction_valid and clears inject_active.
  - Grants nothing; words offered during flush are not taken.
  - Has priority over push, pop and load in the same cycle.
- **Pointers.** Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty come from fifo_count.
- **Reset values.**
  - instruction_word = 0 (NOP encoding)
  - instruction_valid = 0, inject_active = 0, fifo_count = 0, inj_ready = 0, pc_hold = 0
  - FSM in FETCH

## Timing
- **Injection latency.** A push at edge k means the word can load at edge k+1 and is visible after it, provided decode_ready or the output is empty.
- **Program-memory latency.** prog_mem_out sampled at edge k is visible after edge k.
- **Stall.** When decode_ready=0 with valid output, instruction_word and instruction_valid stay stable.
- **Push and pop together.** In the same cycle on a non-full FIFO, fifo_count is unchanged.
- **Reset mid-operation.** Asynchronous assertion clears all state immediately. Pending injections are lost, and sources must re-request.

## Configuration
- INST_INJECT_BYPASS_EN defined: when the FIFO is empty, load=1 and a grant occurs, the granted word is written directly into the output register at the same edge and the FIFO is not pushed.
  - Injection latency drops to 1 cycle.
  - inject_active is 1 for that word.
  - The program word presented that cycle is not loaded, and pc_hold is asserted that cycle.
- Undefined: every injection passes through the FIFO with 2-cycle latency.

## Structure
- Shared package/header inst_inject_pkg holds:
  - NOP_WORD constant (all zeros)
  - FSM state encodings ST_FETCH and ST_INJECT
  - a default WORD_W
- Sub-module inst_inject_fifo: synchronous FIFO parametrised by WORD_W and FIFO_DEPTH, with push/pop/flush inputs and count/full/empty outputs. Arbiter, FSM and output register live in the top.

## Test plan
- Reset, then prog_mem_valid=1 with words 0x1111_0001, 0x1111_0002 and decode_ready=1 → each visible one cycle after presentation. inject_active=0, pc_hold=0.
- inj_valid=2'b11, src0=0xAAAA_0000, src1=0xBBBB_0000 → src0 granted first, then src1.
  - Output sequence 0xAAAA_0000, 0xBBBB_0000, then the held program word.
  - pc_hold=1 until the FIFO drains.
- decode_ready=0 with 5 injection requests and FIFO_DEPTH=4 → fifo_count reaches 4, inj_ready=0, instruction_word stable. Releasing decode_ready drains them in order.
- FIFO holding 3 words, then flush=1 with inj_valid=1 → fifo_count=0, instruction_valid=0, no grant. FSM in FETCH on the next cycle.
- rst asserted mid-drain (fifo_count=2) → all outputs at reset values before the next clock edge. After release, program fetch resumes.
- With INST_INJECT_BYPASS_EN defined, an empty FIFO and injection 0xCCCC_0000 → visible after 1 edge with inject_active=1 and fifo_count staying 0. Without the macro → visible after 2 edges.
